// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns a one-cycle read/write command from the
// control unit into a held mem_req/mem_ack handshake with a bounded wait.
module dmem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [3:0]        MEMCtrl,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              dacq,
  output logic              dbusy,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] cnt;
  logic       cmd_rd;
  logic       cmd_wr;
  logic       cmd_ok;
  logic       cmd_bad;
  logic       unused_ctrl_bits;

  assign cmd_rd  = MEMCtrl[0];
  assign cmd_wr  = MEMCtrl[1];
  assign cmd_ok  = cmd_rd ^ cmd_wr;
  assign cmd_bad = cmd_rd & cmd_wr;
  assign unused_ctrl_bits = ^MEMCtrl[3:2];

  // Handshake outputs decode straight from state so no input reaches them.
  assign mem_req = (state == REQ);
  assign dacq    = (state == DONE);
  assign dbusy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cmd_ok) begin
          next_state = REQ;
        end
      end
      REQ: begin
        if (mem_ack || (cnt == CNT_LAST)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // An acknowledge wins over expiry when both land on the same edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt       <= 8'd0;
      rd_data   <= '0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_ok) begin
            mem_we    <= cmd_wr;
            mem_addr  <= addr;
            mem_wdata <= wr_data;
            cnt       <= 8'd0;
          end else if (cmd_bad) begin
            err <= 1'b1;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (!mem_we) begin
              rd_data <= mem_rdata;
            end
          end else if (cnt == CNT_LAST) begin
            err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed and random checks for dmem_ctrl against a cycle-level reference
// model, with completions matched through a scoreboard queue.
module tb_dmem_ctrl;

  localparam int TIMEOUT = 16;
  localparam int M_IDLE  = 0;
  localparam int M_REQ   = 1;
  localparam int M_DONE  = 2;

  typedef struct packed {
    logic [7:0] rd;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rstn;
  logic [3:0] MEMCtrl;
  logic [7:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       dacq;
  logic       dbusy;
  logic       err;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  int         m_state = M_IDLE;
  int         m_cnt   = 0;
  logic [7:0] m_rd    = '0;
  logic       m_we    = 1'b0;
  logic [7:0] m_addr  = '0;
  logic [7:0] m_wdata = '0;
  logic       m_err   = 1'b0;
  logic       prev_dacq = 1'b0;

  dmem_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .MEMCtrl(MEMCtrl), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .dacq(dacq), .dbusy(dbusy), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the reference model over the coming edge, then clock the DUT.
  task automatic applyStimulus();
    if (!rstn) begin
      m_state = M_IDLE; m_cnt = 0; m_rd = '0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      case (m_state)
        M_IDLE: begin
          if (MEMCtrl[1:0] == 2'b01 || MEMCtrl[1:0] == 2'b10) begin
            m_we = MEMCtrl[1]; m_addr = addr; m_wdata = wr_data;
            m_cnt = 0; m_state = M_REQ;
          end else if (MEMCtrl[1:0] == 2'b11) begin
            m_err = 1'b1;
          end
        end
        M_REQ: begin
          if (mem_ack) begin
            if (!m_we) m_rd = mem_rdata;
            m_state = M_DONE;
            sb.push_back('{rd: m_rd, err: 1'b0});
          end else if (m_cnt == TIMEOUT - 1) begin
            m_err = 1'b1;
            m_state = M_DONE;
            sb.push_back('{rd: m_rd, err: 1'b1});
          end else begin
            m_cnt++;
          end
        end
        default: m_state = M_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkOutput();
    check("mem_req", mem_req, m_state == M_REQ);
    check("dbusy", dbusy, m_state != M_IDLE);
    check("dacq", dacq, m_state == M_DONE);
    check("err", err, m_err);
    check("rd_data", rd_data, m_rd);
    check("mem_we", mem_we, m_we);
    check("mem_addr", mem_addr, m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
  endtask

  task automatic drive(input logic [3:0] c, input logic ack, input logic [7:0] rdat);
    MEMCtrl = c; mem_ack = ack; mem_rdata = rdat;
    applyStimulus();
  endtask

  // Completion monitor: each dacq consumes exactly one expected result.
  always @(negedge clk) begin
    if (dacq === 1'b1) begin
      check("dacq_back_to_back", prev_dacq, 1'b0);
      check("dacq_has_command", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_rd_data", rd_data, e.rd);
        check("sb_err", err, e.err);
      end
    end
    prev_dacq = (dacq === 1'b1);
  end

  initial begin
    int n;
    rstn = 1'b0; MEMCtrl = '0; addr = '0; wr_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    applyStimulus();
    applyStimulus();
    rstn = 1'b1;
    drive(4'b0000, 1'b1, 8'hFF);

    // Read acknowledged one cycle after issue
    addr = 8'h3C; wr_data = 8'h77;
    drive(4'b0001, 1'b0, 8'h00);
    check("rd_issue_addr", mem_addr, 8'h3C);
    drive(4'b0010, 1'b1, 8'hA5);
    check("rd_dacq", dacq, 1'b1);
    check("rd_value", rd_data, 8'hA5);
    drive(4'b0000, 1'b0, 8'h00);

    // Write acknowledged after five request cycles; upper command bits ignored
    addr = 8'h10; wr_data = 8'h5A;
    n = 0;
    drive(4'b1110, 1'b0, 8'h11);
    if (mem_req) n++;
    for (int i = 0; i < 4; i++) begin
      addr = 8'hEE; wr_data = 8'h00;
      drive(4'b0001, 1'b0, 8'h22);
      if (mem_req) n++;
      check("wr_wdata_hold", mem_wdata, 8'h5A);
    end
    drive(4'b0000, 1'b1, 8'h33);
    check("wr_req_cycles", n, 5);
    check("wr_rd_unchanged", rd_data, 8'hA5);
    drive(4'b0000, 1'b0, 8'h00);

    // Timeout with no acknowledge
    addr = 8'h44;
    n = 0;
    drive(4'b0001, 1'b0, 8'h99);
    if (mem_req) n++;
    for (int i = 0; i < 40 && !dacq; i++) begin
      drive(4'b0000, 1'b0, 8'h99);
      if (mem_req) n++;
    end
    check("to_req_cycles", n, 16);
    check("to_dacq", dacq, 1'b1);
    check("to_err", err, 1'b1);
    check("to_rd_unchanged", rd_data, 8'hA5);
    drive(4'b0000, 1'b1, 8'h99);

    // Illegal command
    drive(4'b0011, 1'b1, 8'h00);
    check("ill_err", err, 1'b1);
    check("ill_req", mem_req, 1'b0);
    drive(4'b0000, 1'b0, 8'h00);
    check("ill_err_clear", err, 1'b0);

    // Reset during the second request cycle, late acknowledge ignored
    addr = 8'h20;
    drive(4'b0001, 1'b0, 8'h00);
    drive(4'b0000, 1'b0, 8'h00);
    rstn = 1'b0;
    drive(4'b0000, 1'b0, 8'h00);
    check("rst_req", mem_req, 1'b0);
    check("rst_rd", rd_data, 8'h00);
    rstn = 1'b1;
    drive(4'b0000, 1'b1, 8'hC3);
    check("rst_ack_ignored", dacq, 1'b0);
    drive(4'b0000, 1'b0, 8'h00);

    // Random commands and acknowledges
    for (int i = 0; i < 50; i++) begin
      addr = 8'($urandom_range(0, 255));
      wr_data = 8'($urandom_range(0, 255));
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 20; i++) drive(4'b0000, 1'b1, 8'h00);
    @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: ADDR_W, 8, address width.
REQ-002 Parameter: DATA_W, 8, data width.
REQ-003 Parameter: TIMEOUT, 16, max cycles mem_req is held without mem_ack (range 2..255).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  synchronous, active-low reset.
REQ-006 MEMCtrl  input  4  command from Control_Unit: bit0 read, bit1 write; bits 3:2 ignored.
REQ-007 addr  input  ADDR_W  access address, sampled with the command.
REQ-008 wr_data  input  DATA_W  write data, sampled with the command.
REQ-009 rd_data  output  DATA_W  registered read data.
REQ-010 dacq  output  1  one-cycle completion pulse to Control_Unit.
REQ-011 dbusy  output  1  high whenever the state is not IDLE.
REQ-012 err  output  1  one-cycle error pulse.
REQ-013 mem_req  output  1  memory request, held until acknowledged.
REQ-014 mem_we  output  1  1 write, 0 read; valid while mem_req=1.
REQ-015 mem_addr  output  ADDR_W  latched address.
REQ-016 mem_wdata  output  DATA_W  latched write data.
REQ-017 mem_rdata  input  DATA_W  memory read data, valid with mem_ack.
REQ-018 mem_ack  input  1  memory acknowledge.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, REQ, DONE.
REQ-020 IDLE, exactly one of MEMCtrl[1:0] set at an edge: SHALL latch addr, wr_data and op (mem_we = MEMCtrl[1]), clear the timeout counter, and go to REQ.
REQ-021 IDLE, MEMCtrl[1:0]=2'b11: SHALL pulse err for one cycle, stay in IDLE, issue no memory access, and leave dacq at 0.
REQ-022 IDLE, MEMCtrl[1:0]=2'b00: SHALL stay in IDLE with no output change.
REQ-023 mem_req SHALL be 1 exactly while in REQ; mem_we, mem_addr and mem_wdata SHALL hold their latched values for the whole of REQ.
REQ-024 REQ, mem_ack=1 at an edge: SHALL go to DONE; for a read, rd_data SHALL load mem_rdata at that same edge.
REQ-025 REQ, mem_ack=0: the timeout counter SHALL increment each cycle.
REQ-026 REQ, counter reaches TIMEOUT-1 with mem_ack still 0: SHALL go to DONE with err=1; rd_data SHALL be unchanged.
REQ-027 DONE SHALL last exactly one cycle with dacq=1, then return to IDLE; on timeout, err SHALL be 1 in the same cycle as dacq.
REQ-028 MEMCtrl SHALL be ignored in REQ and DONE; the next command is accepted only in IDLE, so back-to-back accesses take at least 3 cycles each.
REQ-029 mem_ack SHALL be ignored in IDLE and DONE.
REQ-030 Latency: command sampled at edge k with mem_ack=1 at edge k+1 SHALL give dacq=1 in the cycle after edge k+1 (2 cycles from command to dacq).
REQ-031 Writes SHALL never modify rd_data.
REQ-032 All outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from an input to an output.

Reset
REQ-033 rstn=0 at an edge SHALL force IDLE, clear the timeout counter, and set rd_data, dacq, err, mem_req, mem_we, mem_addr and mem_wdata to 0, with dbusy=0.
REQ-034 Reset asserted in REQ SHALL drop mem_req at that edge and produce no dacq; a mem_ack arriving later SHALL be ignored.
REQ-035 Reset SHALL take priority over every other event at the same edge.

Verification
REQ-036 Read, ack one cycle after issue: MEMCtrl=4'b0001, addr=8'h3C, mem_rdata=8'hA5 -> mem_addr=8'h3C, mem_we=0, one-cycle dacq, rd_data=8'hA5, err=0.
REQ-037 Write, ack delayed 5 cycles: MEMCtrl=4'b0010, addr=8'h10, wr_data=8'h5A -> mem_req high for 5 cycles, mem_wdata=8'h5A stable throughout, dacq once, rd_data unchanged.
REQ-038 Timeout: read with mem_ack held 0 and TIMEOUT=16 -> mem_req high exactly 16 cycles, then dacq=1 and err=1 in the same cycle, rd_data unchanged.
REQ-039 Illegal command: MEMCtrl=4'b0011 -> err pulse for one cycle, mem_req stays 0, dacq stays 0, dbusy stays 0.
REQ-040 Reset mid-REQ: rstn=0 on the second REQ cycle, mem_ack=1 one cycle later -> all outputs 0, no dacq, FSM in IDLE.
REQ-041 Random MEMCtrl and mem_ack for 50 cycles -> dacq never high on two consecutive cycles, and every dacq is preceded by exactly one accepted command.
